icache_axi_rd_engine: RTL and testbench
=======================================

Name: icache_axi_rd_engine

Overview:
- AXI4 read-burst engine directly downstream of the instruction prefetcher.
- Accepts one read request at a time:
  - type 0: uncached word
  - type 1: single 32-byte line
  - type 2: double line, 64 bytes
- Drives the 32-bit AXI AR/R channels and assembles beats into a 512-bit return register.
- Signals a half-return after the first line of a double-line fill, and a full return at the end.

Parameters:
ARID, 4'd0, constant AXI ID driven on arid; returned rid is not checked

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
rd_req  in  1  request valid from prefetcher
rd_type  in  2  0 = word, 1 = line (8 beats), 2 = double line (16 beats); 3 treated as 1
rd_addr  in  32  byte address
rd_rdy  out  1  request accepted when rd_req && rd_rdy
ret_valid  out  1  one-cycle pulse, whole request data valid
ret_half  out  1  one-cycle pulse, ret_data[255:0] valid (type 2 only)
ret_data  out  512  assembled data
arid  out  4  = ARID
araddr  out  32  burst address
arlen  out  8  beats-1
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01 (INCR)
arlock  out  2  constant 0
arcache  out  4  4'b0000 for type 0, 4'b0011 otherwise
arprot  out  3  constant 3'b100
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored
rdata  in  32  read data
rresp  in  2  ignored; data stored regardless
rlast  in  1  ignored; beat counter is authoritative
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- **States:** IDLE, AR1, R1, AR2, R2. All state changes on posedge clk.
- **Reset:**
  - state = IDLE; rd_rdy = 1.
  - ret_valid, ret_half, arvalid, rready = 0.
  - ret_data, araddr, arlen, beat counter = 0.
  - Reset mid-burst abandons the transaction; legal only with system-wide reset.
- **Request acceptance:**
  - rd_rdy = (state == IDLE), combinational.
  - On accept, latch type and address.
  - Type 0: araddr = rd_addr with [1:0] = 0; arlen = 0.
  - Types 1/2: araddr = rd_addr with [4:0] = 0.
  - Type 1: arlen = 7.
  - Type 2: arlen = 15, except the split case below.
  - Clear ret_data to 0. Go to AR1.
- **4 KB split:** type 2 with addr[11:5] == 7'h7F would cross a 4 KB boundary.
  - Issue two 8-beat bursts: arlen = 7 at base, then arlen = 7 at base + 32.
- **AR1 / AR2:**
  - arvalid = 1; araddr and arlen are held stable while arvalid is high.
  - On arready, go to R1 / R2.
- **R1 / R2:**
  - rready = 1.
  - Each rvalid beat writes rdata into ret_data[32*cnt +: 32], where cnt is a 4-bit beat counter starting at 0 per request and continuing across the split.
- **End of R1:**
  - Type 0: after beat 0, go to IDLE.
  - Type 1: after beat 7, go to IDLE.
  - Type 2 unsplit: after beat 15, go to IDLE.
  - Type 2 split: after beat 7, go to AR2, which then goes to R2; after beat 15, go to IDLE.
- **ret_half:**
  - Registered.
  - Pulses one cycle in the cycle after beat 7 of a type 2 request is accepted.
  - ret_data[255:0] is complete in that cycle and remains stable until the next accept.
- **ret_valid:**
  - Registered.
  - Pulses one cycle in the cycle after the final beat is accepted; state is already IDLE.
  - ret_half and ret_valid are never high together.
- **Back-to-back:** a new request may be accepted in the same cycle ret_valid pulses. ret_data stays valid in that cycle, because clearing takes effect on the next edge.
- **Minimum latency**, arready and rvalid always high:
  - Type 0: accept at T, arvalid T+1, beat T+2, ret_valid T+3.
  - Type 1: ret_valid T+10.
  - Type 2 unsplit: ret_half T+10, ret_valid T+18.
- **Ordering and stalls:**
  - Only one outstanding transaction; no reordering.
  - rvalid low stalls the beat counter without limit.

Test Plan:
- Type 0, addr 0x1FC0_0004, rdata 0xDEADBEEF, zero-wait slave -> araddr 0x1FC00004, arlen 0, arcache 0; ret_valid at T+3; ret_data[31:0] = 0xDEADBEEF, upper bits 0; no ret_half.
- Type 1, addr 0x0000_1234, beats 0..7 = i+1 -> araddr 0x00001220, arlen 7; ret_valid at T+10; ret_data[32*i +: 32] = i+1; ret_data[511:256] = 0.
- Type 2, addr 0x0000_0100, rvalid gapped every other cycle -> single burst arlen 15; ret_half one cycle after beat 7 with [255:0] correct; ret_valid one cycle after beat 15; 16 words in order.
- Type 2, addr 0x0000_0FE0 -> two AR handshakes: (0x0FE0, 7) then (0x1000, 7); ret_half after first burst; ret_valid after second; data contiguous.
- arready held low 5 cycles -> arvalid, araddr, arlen stable throughout; rd_rdy = 0; no ret pulses.
- Second request presented during the ret_valid cycle of the first -> accepted that cycle; first request's ret_data correct in the pulse cycle; second completes normally. Then resetn low mid-R1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/icache_axi_rd_engine.sv
// AXI4 read-burst engine for the instruction prefetcher: word, line and double-line fills
// assembled into a 512-bit return register, with a half-return after the first line.
module icache_axi_rd_engine #(
    parameter logic [3:0] ARID = 4'd0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [1:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_half,
    output logic [511:0] ret_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    typedef enum logic [2:0] {
        IDLE,
        AR1,
        R1,
        AR2,
        R2
    } state_t;

    state_t      state;
    logic [1:0]  req_type;   // 0 word, 1 line, 2 double line (3 folded into 1 on accept)
    logic        split;
    logic [3:0]  cnt;
    logic        beat;
    logic        r1_done;
    logic        r1_to_ar2;

    // The beat counter is authoritative, so rid/rresp/rlast are deliberately unused.
    logic unused_r_sideband;
    assign unused_r_sideband = &{1'b0, rid, rresp, rlast};

    assign rd_rdy  = (state == IDLE);
    assign arid    = ARID;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arprot  = 3'b100;
    assign arcache = (req_type == 2'd0) ? 4'b0000 : 4'b0011;

    assign beat = rready && rvalid;

    always_comb begin
        r1_done   = 1'b0;
        r1_to_ar2 = 1'b0;
        case (req_type)
            2'd0:    r1_done = (cnt == 4'd0);
            2'd1:    r1_done = (cnt == 4'd7);
            default: begin
                if (split) r1_to_ar2 = (cnt == 4'd7);
                else       r1_done   = (cnt == 4'd15);
            end
        endcase
    end

    // NOTE: resetn is synchronous, so it is tested inside the clocked block and not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            req_type  <= 2'd0;
            split     <= 1'b0;
            cnt       <= 4'd0;
            ret_valid <= 1'b0;
            ret_half  <= 1'b0;
            ret_data  <= '0;
            araddr    <= 32'd0;
            arlen     <= 8'd0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees pre-edge values of the others.
            ret_valid <= 1'b0;
            ret_half  <= 1'b0;

            if (beat) begin
                ret_data[{cnt, 5'b0} +: 32] <= rdata;
                cnt <= cnt + 4'd1;
                if (req_type == 2'd2 && cnt == 4'd7)
                    ret_half <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rd_req) begin
                        req_type <= (rd_type == 2'd3) ? 2'd1 : rd_type;
                        split    <= (rd_type == 2'd2) && (rd_addr[11:5] == 7'h7F);
                        if (rd_type == 2'd0) begin
                            araddr <= {rd_addr[31:2], 2'b00};
                            arlen  <= 8'd0;
                        end else begin
                            araddr <= {rd_addr[31:5], 5'b00000};
                            // A double line starting in the last line of a 4 KB page is split in two.
                            if (rd_type == 2'd2 && rd_addr[11:5] != 7'h7F)
                                arlen <= 8'd15;
                            else
                                arlen <= 8'd7;
                        end
                        ret_data <= '0;
                        cnt      <= 4'd0;
                        arvalid  <= 1'b1;
                        state    <= AR1;
                    end
                end
                AR1: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R1;
                    end
                end
                R1: begin
                    if (beat) begin
                        if (r1_done) begin
                            rready    <= 1'b0;
                            ret_valid <= 1'b1;
                            state     <= IDLE;
                        end else if (r1_to_ar2) begin
                            rready  <= 1'b0;
                            araddr  <= araddr + 32'd32;
                            arlen   <= 8'd7;
                            arvalid <= 1'b1;
                            state   <= AR2;
                        end
                    end
                end
                AR2: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R2;
                    end
                end
                R2: begin
                    if (beat && cnt == 4'd15) begin
                        rready    <= 1'b0;
                        ret_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_engine.sv
// Directed bench for icache_axi_rd_engine: table of requests run against a small AXI slave,
// plus hand sequences for back-to-back acceptance and mid-burst reset.
module tb_icache_axi_rd_engine;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [1:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_half;
    logic [511:0] ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [1:0]   arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    icache_axi_rd_engine dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_half  (ret_half),
        .ret_data  (ret_data),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arlock    (arlock),
        .arcache   (arcache),
        .arprot    (arprot),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One request: inputs, slave behaviour, and hand-computed expectations.
    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        bit          gap;        // rvalid only on odd cycles
        int          stall;      // cycles arready is held low on the first AR
        logic [31:0] base;       // beat i carries base + i
        logic [31:0] araddr0;
        logic [7:0]  arlen0;
        logic [3:0]  arcache;
        int          ar_n;
        logic [31:0] araddr1;
        int          beats;
        int          half_abs;   // cycle of ret_half after accept, -1 = not checked
        int          valid_abs;  // cycle of ret_valid after accept, -1 = not checked
    } vec_t;

    vec_t vecs [6];

    // Called just after a negedge; presents the request in the current cycle (cycle 0) and
    // returns at the negedge where ret_valid is seen, so a follow-up request lands in that cycle.
    task automatic run_vec(input vec_t v);
        int n = 0;
        int ar_n = 0;
        int beat_i = 0;
        int half_t = -1;
        int valid_t = -1;
        int last_t = -1;
        int beat7_t = -1;
        int stall_left = v.stall;
        logic [31:0] ar_addr [2];
        logic [7:0]  ar_len [2];
        logic [3:0]  ar_cache = 4'hF;
        logic [511:0] exp = '0;
        logic [31:0] hold_addr = 32'd0;
        logic [7:0]  hold_len = 8'd0;
        bit seen_ar = 1'b0;
        bit stable_ok = 1'b1;
        bit apart_ok = 1'b1;
        bit done = 1'b0;
        logic rdy_at_valid = 1'b0;

        ar_addr[0] = 32'd0; ar_addr[1] = 32'd0;
        ar_len[0] = 8'd0;   ar_len[1] = 8'd0;
        for (int i = 0; i < v.beats; i++) exp[32*i +: 32] = v.base + 32'(i);

        rvalid = 1'b0; arready = 1'b0;
        rd_type = v.typ; rd_addr = v.addr; rd_req = 1'b1;
        check("accept_rdy", rd_rdy, 1);

        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            rd_req = 1'b0; rd_type = 2'd0; rd_addr = 32'd0;
            if (ret_half && ret_valid) apart_ok = 1'b0;
            if (ret_half) begin
                half_t = n;
                check("half_data", ret_data[255:0], exp[255:0]);
            end
            if (ret_valid) begin
                valid_t = n;
                rdy_at_valid = rd_rdy;
                done = 1'b1;
            end else begin
                if (arvalid) begin
                    if (!seen_ar) begin
                        seen_ar = 1'b1; hold_addr = araddr; hold_len = arlen;
                    end else if (araddr !== hold_addr || arlen !== hold_len) stable_ok = 1'b0;
                    if (stall_left > 0) begin
                        if (rd_rdy || ret_half) stable_ok = 1'b0;
                        arready = 1'b0;
                        stall_left--;
                    end else begin
                        arready = 1'b1;
                        if (ar_n < 2) begin
                            ar_addr[ar_n] = araddr; ar_len[ar_n] = arlen;
                        end
                        if (ar_n == 0) ar_cache = arcache;
                        ar_n++;
                        seen_ar = 1'b0;
                    end
                end else arready = 1'b0;
                rvalid = v.gap ? n[0] : 1'b1;
                rdata = v.base + 32'(beat_i);
                if (rvalid && rready) begin
                    if (beat_i == 7) beat7_t = n;
                    last_t = n;
                    beat_i++;
                end
            end
        end
        rvalid = 1'b0; arready = 1'b0;

        if (!done) check("timeout", 0, 1);
        check("ret_data", ret_data, exp);
        check("idle_at_valid", rdy_at_valid, 1);
        check("ar_count", ar_n, v.ar_n);
        check("araddr0", ar_addr[0], v.araddr0);
        check("arlen0", ar_len[0], v.arlen0);
        check("arcache", ar_cache, v.arcache);
        if (v.ar_n == 2) begin
            check("araddr1", ar_addr[1], v.araddr1);
            check("arlen1", ar_len[1], 8'd7);
        end
        check("beats", beat_i, v.beats);
        check("valid_after_last", valid_t, last_t + 1);
        check("half_after_beat7", half_t, (v.typ == 2'd2) ? beat7_t + 1 : -1);
        if (v.valid_abs >= 0) check("valid_latency", valid_t, v.valid_abs);
        if (v.half_abs >= 0) check("half_latency", half_t, v.half_abs);
        check("ar_stable", stable_ok, 1);
        check("half_valid_apart", apart_ok, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_rdy"}, rd_rdy, 1);
        check({tag, "_ret_valid"}, ret_valid, 0);
        check({tag, "_ret_half"}, ret_half, 0);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_ret_data"}, ret_data, 0);
        check({tag, "_araddr"}, araddr, 0);
        check({tag, "_arlen"}, arlen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          typ    addr           gap  stall base           araddr0        arlen0 cache ar_n araddr1     beats half valid
        vecs[0] = '{2'd0, 32'h1FC0_0004, 1'b0, 0, 32'hDEAD_BEEF, 32'h1FC0_0004, 8'd0,  4'h0, 1, 32'h0,       1,  -1,  3};
        vecs[1] = '{2'd1, 32'h0000_1234, 1'b0, 0, 32'h0000_0001, 32'h0000_1220, 8'd7,  4'h3, 1, 32'h0,       8,  -1,  10};
        vecs[2] = '{2'd2, 32'h0000_0100, 1'b1, 0, 32'h0000_0100, 32'h0000_0100, 8'd15, 4'h3, 1, 32'h0,       16, -1,  -1};
        vecs[3] = '{2'd2, 32'h0000_0FE0, 1'b0, 0, 32'h0000_A000, 32'h0000_0FE0, 8'd7,  4'h3, 2, 32'h0000_1000, 16, 10, 19};
        vecs[4] = '{2'd2, 32'h0000_0040, 1'b0, 0, 32'h0000_5000, 32'h0000_0040, 8'd15, 4'h3, 1, 32'h0,       16, 10,  18};
        vecs[5] = '{2'd3, 32'h2000_0044, 1'b0, 5, 32'h0000_0700, 32'h2000_0040, 8'd7,  4'h3, 1, 32'h0,       8,  -1,  15};

        resetn = 1'b0; rd_req = 1'b0; rd_type = 2'd0; rd_addr = 32'd0;
        arready = 1'b0; rid = 4'd5; rdata = 32'd0; rresp = 2'b10; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("arid", arid, 4'd0);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);
        check("arlock", arlock, 2'b00);
        check("arprot", arprot, 3'b100);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Second request presented in the ret_valid cycle of the first.
        run_vec(vecs[1]);
        run_vec(vecs[0]);
        repeat (2) @(negedge clk);

        // Reset in the middle of an R1 burst.
        rd_type = 2'd1; rd_addr = 32'h0000_0300; rd_req = 1'b1;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_r1_rready", rready, 1);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        resetn = 1'b1; rvalid = 1'b0; arready = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
